// File: rtl/phoenix_input_buffer_pkg.sv
//------------------------------------------------------------------------------
// Module : phoenix_package
// Brief  : Shared router constants, port indices and input-buffer states.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package phoenix_package;

    localparam int TAM_FLIT   = 16;
    localparam int TAM_BUFFER = 4;
    localparam int NPORT      = 5;

    localparam int EAST  = 0;
    localparam int WEST  = 1;
    localparam int NORTH = 2;
    localparam int SOUTH = 3;
    localparam int LOCAL = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_HDR     = 3'd2,
        S_SIZE    = 3'd3,
        S_PAYLOAD = 3'd4,
        S_END     = 3'd5
    } buffer_state_t;

endpackage

`default_nettype wire

// File: rtl/phoenix_input_buffer_fifo_core.sv
//------------------------------------------------------------------------------
// Module : phoenix_fifo_core
// Brief  : Circular flit store with read/write pointers, occupancy and credit.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module phoenix_fifo_core #(
    parameter int WIDTH = phoenix_package::TAM_FLIT,
    parameter int DEPTH = phoenix_package::TAM_BUFFER
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     pop,
    output logic                     credit_o,
    output logic [WIDTH-1:0]         data_out,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_first;
    logic [PTR_W-1:0] r_last;
    logic [CNT_W-1:0] r_count;
    logic             w_credit;
    logic             w_write;

    // Credit comes from the registered count, so a pop on a full buffer
    // does not open a write slot until the following cycle.
    assign w_credit = (r_count != CNT_W'(DEPTH));
    assign w_write  = push && w_credit;

    always_ff @(posedge clock) begin
        if (w_write) begin
            r_mem[r_last] <= data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_first <= '0;
            r_last  <= '0;
            r_count <= '0;
        end else begin
            if (w_write) begin
                r_last <= r_last + PTR_W'(1);
            end
            if (pop) begin
                r_first <= r_first + PTR_W'(1);
            end
            case ({w_write, pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign credit_o = w_credit;
    assign data_out = r_mem[r_first];
    assign count    = r_count;

endmodule

`default_nettype wire

// File: rtl/phoenix_input_buffer.sv
//------------------------------------------------------------------------------
// Module : phoenix_input_buffer
// Brief  : Router input port: credit FIFO plus packet-forwarding control.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module phoenix_input_buffer #(
    parameter int TAM_FLIT   = phoenix_package::TAM_FLIT,
    parameter int TAM_BUFFER = phoenix_package::TAM_BUFFER
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                rx,
    input  logic [TAM_FLIT-1:0] data_in,
    output logic                credit_o,
    output logic                h,
    input  logic                ack_h,
    output logic [TAM_FLIT-1:0] data_out,
    output logic                data_av,
    input  logic                data_ack,
    output logic                sender
);

    import phoenix_package::*;

    localparam int CNT_W = $clog2(TAM_BUFFER) + 1;

    buffer_state_t       r_state;
    buffer_state_t       w_state_next;
    logic [TAM_FLIT-1:0] r_flit_cnt;
    logic [TAM_FLIT-1:0] w_flit_cnt_next;
    logic [CNT_W-1:0]    w_count;
    logic                w_in_packet;
    logic                w_pop;

    phoenix_fifo_core #(
        .WIDTH (TAM_FLIT),
        .DEPTH (TAM_BUFFER)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (rx),
        .data_in  (data_in),
        .pop      (w_pop),
        .credit_o (credit_o),
        .data_out (data_out),
        .count    (w_count)
    );

    assign w_in_packet = (r_state == S_HDR) || (r_state == S_SIZE) || (r_state == S_PAYLOAD);
    assign data_av     = w_in_packet && (w_count != '0);
    assign sender      = w_in_packet;
    assign h           = (r_state == S_REQ);
    assign w_pop       = data_av && data_ack;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_flit_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_flit_cnt <= w_flit_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_flit_cnt_next = r_flit_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_count != '0) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (ack_h) begin
                    w_state_next = S_HDR;
                end
            end
            S_HDR: begin
                if (w_pop) begin
                    w_state_next = S_SIZE;
                end
            end
            S_SIZE: begin
                // The size flit is latched as it leaves; zero means header+size only.
                if (w_pop) begin
                    w_flit_cnt_next = data_out;
                    w_state_next    = (data_out == '0) ? S_END : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (w_pop) begin
                    w_flit_cnt_next = r_flit_cnt - TAM_FLIT'(1);
                    if (r_flit_cnt == TAM_FLIT'(1)) begin
                        w_state_next = S_END;
                    end
                end
            end
            S_END: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_phoenix_input_buffer.sv
//------------------------------------------------------------------------------
// Module : tb_phoenix_input_buffer
// Brief  : Scoreboard bench: directed packets, queued expected flits.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_phoenix_input_buffer;

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic        rx       = 1'b0;
    logic [15:0] data_in  = 16'h0000;
    logic        ack_h    = 1'b0;
    logic        data_ack = 1'b0;
    logic        credit_o;
    logic        h;
    logic [15:0] data_out;
    logic        data_av;
    logic        sender;

    int          checks       = 0;
    int          failures     = 0;
    int          cycle_no     = 0;
    int          last_pop_cyc = 0;
    logic [15:0] exp_q[$];

    phoenix_input_buffer dut (
        .clock    (clock),
        .reset    (reset),
        .rx       (rx),
        .data_in  (data_in),
        .credit_o (credit_o),
        .h        (h),
        .ack_h    (ack_h),
        .data_out (data_out),
        .data_av  (data_av),
        .data_ack (data_ack),
        .sender   (sender)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle_no++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Monitor: every handshake must match the oldest outstanding flit.
    always @(negedge clock) begin
        if (!reset && data_av && data_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_flit: got %0h expected none", data_out);
            end else begin
                check("flit", {16'h0, data_out}, {16'h0, exp_q.pop_front()});
            end
            check("sender_during_pop", {31'h0, sender}, 32'h1);
            last_pop_cyc = cycle_no;
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [15:0] f, input bit fwd);
        int n = 0;
        while (!credit_o && n < 50) begin
            cyc();
            n++;
        end
        if (!credit_o) fail_now("credit_timeout");
        rx      = 1'b1;
        data_in = f;
        if (fwd) exp_q.push_back(f);
        cyc();
        rx = 1'b0;
    endtask

    task automatic wait_h(output int c);
        int n = 0;
        while (!h && n < 100) begin
            cyc();
            n++;
        end
        if (!h) fail_now("h_timeout");
        c = cycle_no;
    endtask

    task automatic grant();
        int c;
        wait_h(c);
        cyc();
        ack_h = 1'b1;
        cyc();
        ack_h = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            cyc();
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
    endtask

    task automatic check_end(input string tag);
        @(negedge clock);
        check({tag, "_sender_fall"}, {31'h0, sender}, 32'h0);
        check({tag, "_fall_latency"}, cycle_no - last_pop_cyc, 32'd1);
        check({tag, "_data_av_end"}, {31'h0, data_av}, 32'h0);
        cyc();
    endtask

    task automatic check_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check({tag, "_credit"},  {31'h0, credit_o}, 32'h1);
            check({tag, "_h"},       {31'h0, h},        32'h0);
            check({tag, "_sender"},  {31'h0, sender},   32'h0);
            check({tag, "_data_av"}, {31'h0, data_av},  32'h0);
            cyc();
        end
    endtask

    initial begin
        int hc;
        repeat (3) cyc();
        reset = 1'b0;

        check_idle("reset_idle", 10);

        // Basic packet with ack one cycle after h.
        data_ack = 1'b1;
        fork
            begin
                send(16'h0011, 1'b1);
                send(16'h0002, 1'b1);
                send(16'hAAAA, 1'b1);
                send(16'hBBBB, 1'b1);
            end
            begin
                grant();
            end
        join
        drain();
        check_end("basic");
        check_idle("basic_idle", 3);

        // Fill to full, drop a fifth flit, one pop reopens credit.
        data_ack = 1'b0;
        send(16'h0022, 1'b1);
        send(16'h0002, 1'b1);
        send(16'h1111, 1'b1);
        send(16'h2222, 1'b1);
        @(negedge clock);
        check("full_credit", {31'h0, credit_o}, 32'h0);
        rx      = 1'b1;
        data_in = 16'hDEAD;
        cyc();
        rx = 1'b0;
        @(negedge clock);
        check("full_after_drop", {31'h0, credit_o}, 32'h0);
        grant();
        @(negedge clock);
        check("full_hdr_av", {31'h0, data_av}, 32'h1);
        check("full_hdr_credit", {31'h0, credit_o}, 32'h0);
        data_ack = 1'b1;
        cyc();
        data_ack = 1'b0;
        @(negedge clock);
        check("credit_after_pop", {31'h0, credit_o}, 32'h1);
        data_ack = 1'b1;
        drain();
        check_end("full");
        check_idle("full_idle", 5);

        // Zero-size packet: header and size only.
        send(16'h0033, 1'b1);
        send(16'h0000, 1'b1);
        grant();
        drain();
        check_end("zero");
        check_idle("zero_idle", 4);

        // Back-to-back packets; second one arrives during the first's payload.
        send(16'h0044, 1'b1);
        send(16'h0002, 1'b1);
        send(16'h5555, 1'b1);
        send(16'h6666, 1'b1);
        grant();
        send(16'h0055, 1'b1);
        send(16'h0001, 1'b1);
        send(16'h7777, 1'b1);
        wait_h(hc);
        check("b2b_h_latency", hc - last_pop_cyc, 32'd3);
        check("b2b_first_done", exp_q.size(), 32'd3);
        cyc();
        ack_h = 1'b1;
        cyc();
        ack_h = 1'b0;
        drain();
        check_end("b2b");
        check_idle("b2b_idle", 2);

        // Reset in the middle of a payload with three flits buffered.
        data_ack = 1'b0;
        send(16'h0066, 1'b1);
        send(16'h0004, 1'b1);
        send(16'h1234, 1'b1);
        send(16'h5678, 1'b1);
        grant();
        data_ack = 1'b1;
        cyc();
        cyc();
        data_ack = 1'b0;
        send(16'h9ABC, 1'b1);
        @(negedge clock);
        check("mid_sender", {31'h0, sender}, 32'h1);
        check("mid_data_av", {31'h0, data_av}, 32'h1);
        cyc();
        reset = 1'b1;
        exp_q.delete();
        cyc();
        reset = 1'b0;
        check_idle("post_reset", 4);

        data_ack = 1'b1;
        send(16'h0077, 1'b1);
        send(16'h0001, 1'b1);
        send(16'h9999, 1'b1);
        grant();
        drain();
        check_end("fresh");
        check_idle("fresh_idle", 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
